race_start_sequencer: RTL and testbench
=======================================

// Module: race_start_sequencer
// PURPOSE
//  Game-side consumer of the menu's start_game flag. Rising edge of start_game launches the
//  drag-race start sequence: 3-step light countdown, GO, race timing in ms, false-start detect.
//  After a result hold it pulses back_to_menu so the menu FSM regains control.
//  Sits between the menu logic and the car/physics + HUD drawing blocks.
// PARAMETERS
//  STEP_CYCLES    65_000_000   clk cycles per countdown light step (1 s @ 65 MHz)
//  MS_CYCLES      65_000       clk cycles per race-time millisecond tick
//  RESULT_CYCLES  195_000_000  clk cycles result/false-start is held before returning to menu
//  TIME_W         16           width of race_time (ms), saturating
// PORTS
//  clk           in   1       system clock
//  rst           in   1       synchronous, active-high reset
//  start_game    in   1       level from menu; only its 0->1 edge is used
//  gas           in   1       player throttle, already synchronised, active-high
//  finish        in   1       car crossed finish line, active-high (level or pulse)
//  lights        out  3       countdown lamps: 100, 110, 111 per step; 000 otherwise
//  go_light      out  1       high while state RACE
//  race_active   out  1       high while state RACE
//  false_start   out  1       high while state FOUL
//  race_time     out  TIME_W  ms counter; live in RACE, frozen in DONE, 0 in IDLE/COUNT
//  back_to_menu  out  1       single-cycle pulse on leaving DONE/FOUL
// BEHAVIOUR
//  - Single clock domain; all outputs registered. On rst: state IDLE, all outputs 0,
//    start_game edge register 0, all counters 0. Reset mid-sequence aborts immediately.
//  - Edge detect: start_q <= start_game; launch = start_game & ~start_q.
//  - IDLE: launch -> COUNT, step=0, lights=100 visible the cycle after the edge (1-cycle latency).
//    gas/finish ignored in IDLE.
//  - COUNT: cycle counter 0..STEP_CYCLES-1 per step; on wrap step++ and lights 100->110->111;
//    after step 2 wraps -> RACE (lights=000, go_light=1, race_active=1, race_time=0).
//    gas high in any COUNT cycle -> FOUL (checked before step expiry; gas wins on same cycle).
//    gas already held at launch -> FOUL after first COUNT cycle.
//  - RACE: ms prescaler counts 0..MS_CYCLES-1; on wrap race_time++, saturating at 2^TIME_W-1.
//    finish=1 -> DONE; race_time frozen at value before that cycle (coincident tick not counted).
//  - FOUL: lights=000, false_start=1, hold counter runs RESULT_CYCLES.
//  - DONE: race_active=0, go_light=0, race_time held, hold counter runs RESULT_CYCLES.
//  - DONE/FOUL hold expiry -> IDLE, back_to_menu=1 for exactly one cycle, all other outputs 0.
//  - start_game edges outside IDLE ignored (no restart); edge detect register still tracks input,
//    so a level still high on return to IDLE does not relaunch.
//  - Counters sized by $clog2 of their parameter; no combinational path input->output.
// TESTING  (bench params: STEP_CYCLES=4, MS_CYCLES=2, RESULT_CYCLES=6, TIME_W=4)
//  1 rst, start_game 0->1 at cycle 10 -> lights 100 @11, 110 @15, 111 @19, go_light=1 @23.
//  2 Race: finish at cycle 23+9 -> race_time=4 frozen, DONE 6 cycles, back_to_menu 1-cycle pulse,
//    then all outputs 0.
//  3 gas=1 at cycle 17 -> false_start=1 @18, lights=000, race_active never 1; pulse after 6 cycles.
//  4 gas and last step expiry same cycle -> FOUL, not RACE; gas held at launch -> FOUL @12.
//  5 No finish for 40 cycles in RACE -> race_time saturates at 15 and stays.
//  6 start_game toggled during COUNT/RACE -> ignored; rst asserted mid-COUNT -> next cycle all 0.

Source files
------------

// File: rtl/race_start_sequencer.sv
// Drag-race start sequencer: launches on the menu's start_game rising edge, runs the
// light countdown, times the race in ms, flags false starts, then hands control back.
module race_start_sequencer #(
  parameter int unsigned STEP_CYCLES   = 65_000_000,
  parameter int unsigned MS_CYCLES     = 65_000,
  parameter int unsigned RESULT_CYCLES = 195_000_000,
  parameter int unsigned TIME_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_game,
  input  logic              gas,
  input  logic              finish,
  output logic [2:0]        lights,
  output logic              go_light,
  output logic              race_active,
  output logic              false_start,
  output logic [TIME_W-1:0] race_time,
  output logic              back_to_menu
);

  localparam int unsigned STEP_W = (STEP_CYCLES   > 1) ? $clog2(STEP_CYCLES)   : 1;
  localparam int unsigned MS_W   = (MS_CYCLES     > 1) ? $clog2(MS_CYCLES)     : 1;
  localparam int unsigned HOLD_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(MS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESULT_CYCLES - 1);
  localparam logic [TIME_W-1:0] TIME_MAX  = {TIME_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    RACE  = 3'd2,
    FOUL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic              start_q;
  logic              launch;
  logic [1:0]        step;
  logic [STEP_W-1:0] step_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  assign launch = start_game & ~start_q;

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      step         <= 2'd0;
      step_cnt     <= '0;
      ms_cnt       <= '0;
      hold_cnt     <= '0;
      lights       <= 3'b000;
      go_light     <= 1'b0;
      race_active  <= 1'b0;
      false_start  <= 1'b0;
      race_time    <= '0;
      back_to_menu <= 1'b0;
    end else begin
      start_q      <= start_game;
      back_to_menu <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state    <= COUNT;
            step     <= 2'd0;
            step_cnt <= '0;
            lights   <= 3'b100;
          end
        end
        COUNT: begin
          // A throttle press beats a coincident step expiry
          if (gas) begin
            state       <= FOUL;
            lights      <= 3'b000;
            false_start <= 1'b1;
            hold_cnt    <= '0;
            step_cnt    <= '0;
          end else if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            if (step == 2'd2) begin
              state       <= RACE;
              lights      <= 3'b000;
              go_light    <= 1'b1;
              race_active <= 1'b1;
              race_time   <= '0;
              ms_cnt      <= '0;
            end else begin
              step   <= step + 2'd1;
              lights <= {2'b11, step[0]};
            end
          end else begin
            step_cnt <= step_cnt + STEP_W'(1);
          end
        end
        RACE: begin
          // Finish freezes the time as it stood before this cycle's tick
          if (finish) begin
            state       <= DONE;
            go_light    <= 1'b0;
            race_active <= 1'b0;
            hold_cnt    <= '0;
            ms_cnt      <= '0;
          end else if (ms_cnt == MS_LAST) begin
            ms_cnt <= '0;
            if (race_time != TIME_MAX) begin
              race_time <= race_time + TIME_W'(1);
            end
          end else begin
            ms_cnt <= ms_cnt + MS_W'(1);
          end
        end
        FOUL, DONE: begin
          if (hold_cnt == HOLD_LAST) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            step         <= 2'd0;
            lights       <= 3'b000;
            go_light     <= 1'b0;
            race_active  <= 1'b0;
            false_start  <= 1'b0;
            race_time    <= '0;
            back_to_menu <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_race_start_sequencer.sv
// Directed table-driven bench for race_start_sequencer with small timing parameters.
module tb_race_start_sequencer;

  logic       clk;
  logic       rst;
  logic       start_game;
  logic       gas;
  logic       finish;
  logic [2:0] lights;
  logic       go_light;
  logic       race_active;
  logic       false_start;
  logic [3:0] race_time;
  logic       back_to_menu;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  race_start_sequencer #(
    .STEP_CYCLES  (4),
    .MS_CYCLES    (2),
    .RESULT_CYCLES(6),
    .TIME_W       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_game  (start_game),
    .gas         (gas),
    .finish      (finish),
    .lights      (lights),
    .go_light    (go_light),
    .race_active (race_active),
    .false_start (false_start),
    .race_time   (race_time),
    .back_to_menu(back_to_menu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // nt: reset before this row; inputs apply in cycle cyc; exp = outputs seen in cycle cyc
  typedef struct {
    bit          nt;
    int          cyc;
    logic        rst;
    logic        sg;
    logic        gas;
    logic        fin;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit nt, int c, logic r, logic sg, logic g, logic f,
                              logic [2:0] l, logic go, logic act, logic fs,
                              logic [3:0] rt, logic btm);
    vec_t v;
    v.nt  = nt;
    v.cyc = c;
    v.rst = r;
    v.sg  = sg;
    v.gas = g;
    v.fin = f;
    v.exp = {l, go, act, fs, rt, btm};
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    start_game = 1'b0;
    gas        = 1'b0;
    finish     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  function automatic logic [10:0] outs();
    return {lights, go_light, race_active, false_start, race_time, back_to_menu};
  endfunction

  task automatic check(string name, int idx, logic [10:0] got, logic [10:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s vec=%0d cyc=%0d actual=%b required=%b (l,go,act,fs,rt,btm)",
               name, idx, cyc, got, req);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start_game = 1'b0; gas = 1'b0; finish = 1'b0;

    // Full race: countdown, toggles ignored, finish, hold, return, no relaunch
    add(1,  0, 0,0,0,0, 3'b000,0,0,0,4'd0,0);
    add(0, 10, 0,1,0,0, 3'b000,0,0,0,4'd0,0);
    add(0, 11, 0,1,0,0, 3'b100,0,0,0,4'd0,0);
    add(0, 14, 0,1,0,0, 3'b100,0,0,0,4'd0,0);
    add(0, 15, 0,1,0,0, 3'b110,0,0,0,4'd0,0);
    add(0, 16, 0,0,0,0, 3'b110,0,0,0,4'd0,0);
    add(0, 17, 0,1,0,0, 3'b110,0,0,0,4'd0,0);
    add(0, 19, 0,1,0,0, 3'b111,0,0,0,4'd0,0);
    add(0, 22, 0,1,0,0, 3'b111,0,0,0,4'd0,0);
    add(0, 23, 0,1,0,0, 3'b000,1,1,0,4'd0,0);
    add(0, 24, 0,1,0,0, 3'b000,1,1,0,4'd0,0);
    add(0, 25, 0,1,0,0, 3'b000,1,1,0,4'd1,0);
    add(0, 27, 0,0,0,0, 3'b000,1,1,0,4'd2,0);
    add(0, 28, 0,1,0,0, 3'b000,1,1,0,4'd2,0);
    add(0, 29, 0,1,0,0, 3'b000,1,1,0,4'd3,0);
    add(0, 32, 0,1,0,1, 3'b000,1,1,0,4'd4,0);
    add(0, 33, 0,1,0,0, 3'b000,0,0,0,4'd4,0);
    add(0, 38, 0,1,0,0, 3'b000,0,0,0,4'd4,0);
    add(0, 39, 0,1,0,0, 3'b000,0,0,0,4'd0,1);
    add(0, 40, 0,1,0,0, 3'b000,0,0,0,4'd0,0);
    add(0, 45, 0,1,0,0, 3'b000,0,0,0,4'd0,0);
    // False start mid-countdown
    add(1,  0, 0,0,0,0, 3'b000,0,0,0,4'd0,0);
    add(0, 10, 0,1,0,0, 3'b000,0,0,0,4'd0,0);
    add(0, 11, 0,1,0,0, 3'b100,0,0,0,4'd0,0);
    add(0, 17, 0,1,1,0, 3'b110,0,0,0,4'd0,0);
    add(0, 18, 0,1,0,0, 3'b000,0,0,1,4'd0,0);
    add(0, 23, 0,1,0,0, 3'b000,0,0,1,4'd0,0);
    add(0, 24, 0,1,0,0, 3'b000,0,0,0,4'd0,1);
    add(0, 25, 0,1,0,0, 3'b000,0,0,0,4'd0,0);
    // Gas coincident with last step expiry
    add(1,  0, 0,0,0,0, 3'b000,0,0,0,4'd0,0);
    add(0, 10, 0,1,0,0, 3'b000,0,0,0,4'd0,0);
    add(0, 19, 0,1,0,0, 3'b111,0,0,0,4'd0,0);
    add(0, 22, 0,1,1,0, 3'b111,0,0,0,4'd0,0);
    add(0, 23, 0,1,0,0, 3'b000,0,0,1,4'd0,0);
    add(0, 28, 0,1,0,0, 3'b000,0,0,1,4'd0,0);
    add(0, 29, 0,1,0,0, 3'b000,0,0,0,4'd0,1);
    // Gas already held at launch
    add(1,  0, 0,0,0,0, 3'b000,0,0,0,4'd0,0);
    add(0,  5, 0,0,1,0, 3'b000,0,0,0,4'd0,0);
    add(0, 10, 0,1,1,0, 3'b000,0,0,0,4'd0,0);
    add(0, 11, 0,1,1,0, 3'b100,0,0,0,4'd0,0);
    add(0, 12, 0,1,0,0, 3'b000,0,0,1,4'd0,0);
    // Race time saturation
    add(1,  0, 0,0,0,0, 3'b000,0,0,0,4'd0,0);
    add(0, 10, 0,1,0,0, 3'b000,0,0,0,4'd0,0);
    add(0, 23, 0,1,0,0, 3'b000,1,1,0,4'd0,0);
    add(0, 52, 0,1,0,0, 3'b000,1,1,0,4'd14,0);
    add(0, 53, 0,1,0,0, 3'b000,1,1,0,4'd15,0);
    add(0, 63, 0,1,0,1, 3'b000,1,1,0,4'd15,0);
    add(0, 64, 0,1,0,0, 3'b000,0,0,0,4'd15,0);
    // Reset mid-countdown
    add(1,  0, 0,0,0,0, 3'b000,0,0,0,4'd0,0);
    add(0, 10, 0,1,0,0, 3'b000,0,0,0,4'd0,0);
    add(0, 12, 0,1,0,0, 3'b100,0,0,0,4'd0,0);
    add(0, 13, 1,1,0,0, 3'b100,0,0,0,4'd0,0);
    add(0, 14, 0,0,0,0, 3'b000,0,0,0,4'd0,0);
    add(0, 20, 0,0,0,0, 3'b000,0,0,0,4'd0,0);

    foreach (vecs[i]) begin
      if (vecs[i].nt) do_reset();
      while (cyc < vecs[i].cyc) tick();
      rst        = vecs[i].rst;
      start_game = vecs[i].sg;
      gas        = vecs[i].gas;
      finish     = vecs[i].fin;
      @(negedge clk);
      check("outputs", i, outs(), vecs[i].exp);
    end

    // Back-to-menu latency and single-cycle width after an early foul
    do_reset();
    start_game = 1'b1;
    tick();
    gas = 1'b1;
    tick();
    gas = 1'b0;
    @(negedge clk);
    check("foul_entry", -1, outs(), {3'b000, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0});
    n = 0;
    while (!back_to_menu && n < 30) begin
      tick();
      n++;
    end
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL btm_latency: actual=%0d cycles required=6", n);
    end
    tick();
    @(negedge clk);
    check("btm_width", -1, outs(), 11'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
